note_scroller: RTL and testbench

NOTE_SCROLLER -- requirements
Module: note_scroller

---
 rtl/note_scroller_if.sv | 13 +
 rtl/note_scroller.sv | 127 ++++++++++++
 tb/tb_note_scroller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_scroller_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | note_scroller_if : valid/ready handshake for top-row notes  rev 1.0 |
// +---------------------------------------------------------------------+
interface note_scroller_if;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_row;

  modport master (output note_valid, output note_row, input note_ready);
  modport slave  (input note_valid, input note_row, output note_ready);
endinterface
`default_nettype wire

// File: rtl/note_scroller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | note_scroller : scrolling 4-lane note field with hit/miss judging      |
// | rev 1.0 ; optional ghost-press penalty under GUITAR_GHOST_PRESS_EN     |
// +------------------------------------------------------------------------+
module note_scroller #(
  parameter int         ROWS      = 8,
  parameter logic [2:0] PLAY_MODE = 3'd4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [2:0]          mode,
  input  logic [22:0]         diff_speed,
  input  logic [1:0]          level,
  note_scroller_if.slave      note_if,
  input  logic [3:0]          btn,
  output logic                scroll_tick,
  output logic [4*ROWS-1:0]   grid,
  output logic                hit_pulse,
  output logic                miss_pulse,
  output logic [15:0]         score,
  output logic [7:0]          miss_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [22:0] cnt;
  logic        pend_valid;
  logic [3:0]  pend_row;

  logic [22:0] eff_m1;
  logic        run_stay;
  logic        tick_now;
  logic        hs;
  logic [3:0]  strike;
  logic [3:0]  hits;
  logic [3:0]  left;
  logic [1:0]  weight;
  logic [4:0]  score_add;
  logic [3:0]  miss_add;
  logic [16:0] score_sum;
  logic [8:0]  miss_sum;
  logic [3:0]  new_row0;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  // A zero period behaves like a period of one: tick every cycle.
  assign eff_m1   = (diff_speed == 23'd0) ? 23'd0 : diff_speed - 23'd1;
  assign run_stay = (state == RUN) && (mode == PLAY_MODE);
  assign tick_now = run_stay && (cnt >= eff_m1);

  assign note_if.note_ready = (state == RUN) && !pend_valid;
  assign hs = note_if.note_valid && note_if.note_ready;

  assign strike = grid[4*ROWS-1 -: 4];
  assign hits   = run_stay ? (btn & strike) : 4'd0;
  assign left   = strike & ~hits;
  assign weight = (level == 2'd0) ? 2'd1 : level;

  assign score_add = {3'b0, weight} * {2'b0, pop4(hits)};
  assign score_sum = {1'b0, score} + {12'b0, score_add};

`ifdef GUITAR_GHOST_PRESS_EN
  logic [3:0] ghost;
  assign ghost    = run_stay ? (btn & ~strike) : 4'd0;
  assign miss_add = (tick_now ? {1'b0, pop4(left)} : 4'd0) + {1'b0, pop4(ghost)};
`else
  assign miss_add = tick_now ? {1'b0, pop4(left)} : 4'd0;
`endif

  assign miss_sum = {1'b0, miss_count} + {5'b0, miss_add};
  assign new_row0 = pend_valid ? pend_row : (hs ? note_if.note_row : 4'd0);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= 23'd0;
      grid        <= '0;
      pend_valid  <= 1'b0;
      pend_row    <= 4'd0;
      score       <= 16'd0;
      miss_count  <= 8'd0;
      scroll_tick <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      scroll_tick <= tick_now;
      hit_pulse   <= |hits;
      miss_pulse  <= (miss_add != 4'd0);
      score       <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      miss_count  <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
      case (state)
        IDLE: begin
          cnt <= 23'd0;
          if (mode == PLAY_MODE) state <= RUN;
        end
        RUN: begin
          if (mode != PLAY_MODE) begin
            state      <= IDLE;
            cnt        <= 23'd0;
            grid       <= '0;
            pend_valid <= 1'b0;
            pend_row   <= 4'd0;
          end else if (tick_now) begin
            cnt        <= 23'd0;
            grid       <= {grid[4*(ROWS-1)-1:0], new_row0};
            pend_valid <= 1'b0;
          end else begin
            cnt  <= cnt + 23'd1;
            // Hit lanes are cleared in place; the rest of the field holds.
            grid <= {left, grid[4*(ROWS-1)-1:0]};
            if (hs) begin
              pend_valid <= 1'b1;
              pend_row   <= note_if.note_row;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_scroller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_note_scroller : directed + random bench with behavioural model      |
// | rev 1.0 ; honours GUITAR_GHOST_PRESS_EN                                |
// +------------------------------------------------------------------------+
module tb_note_scroller;
  localparam int         ROWS = 8;
  localparam logic [2:0] PM   = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              n_rst;
  logic [2:0]        mode;
  logic [22:0]       diff_speed;
  logic [1:0]        level;
  logic [3:0]        btn;
  logic              scroll_tick, hit_pulse, miss_pulse;
  logic [4*ROWS-1:0] grid;
  logic [15:0]       score;
  logic [7:0]        miss_count;

  note_scroller_if nif();

  note_scroller #(.ROWS(ROWS), .PLAY_MODE(PM)) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .diff_speed(diff_speed),
    .level(level), .note_if(nif), .btn(btn), .scroll_tick(scroll_tick),
    .grid(grid), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .miss_count(miss_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: field as an array of lane masks, pending as a queue.
  logic [3:0] m_rows [ROWS];
  logic [3:0] m_pend [$];
  bit m_run;
  int m_cnt, m_score, m_miss;
  bit m_tick, m_hit, m_mp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*ROWS-1:0] m_grid();
    logic [4*ROWS-1:0] g;
    for (int r = 0; r < ROWS; r++) g[4*r +: 4] = m_rows[r];
    return g;
  endfunction

  task automatic m_clear_field();
    for (int r = 0; r < ROWS; r++) m_rows[r] = 4'd0;
    m_pend.delete();
    m_cnt = 0;
  endtask

  task automatic model_update();
    int eff, w, nhit, nmiss;
    bit tick, hs;
    logic [3:0] s;
    m_tick = 0; m_hit = 0; m_mp = 0;
    if (!n_rst) begin
      m_clear_field(); m_run = 0; m_score = 0; m_miss = 0;
      return;
    end
    if (!m_run) begin
      if (mode == PM) begin m_run = 1; m_cnt = 0; end
      return;
    end
    if (mode != PM) begin
      m_run = 0; m_clear_field();
      return;
    end
    eff  = (diff_speed == 0) ? 1 : int'(diff_speed);
    tick = (m_cnt >= eff - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    hs = nif.note_valid && (m_pend.size() == 0);
    s = m_rows[ROWS-1];
    w = (level == 0) ? 1 : int'(level);
    nhit = 0; nmiss = 0;
    for (int l = 0; l < 4; l++) begin
      if (btn[l] && s[l]) begin nhit++; s[l] = 1'b0; end
`ifdef GUITAR_GHOST_PRESS_EN
      else if (btn[l]) nmiss++;
`endif
    end
    m_score = (m_score + w * nhit > 65535) ? 65535 : m_score + w * nhit;
    if (tick) begin
      nmiss += $countones(s);
      for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
      if (m_pend.size() != 0) m_rows[0] = m_pend.pop_front();
      else m_rows[0] = hs ? nif.note_row : 4'd0;
    end else begin
      m_rows[ROWS-1] = s;
      if (hs) m_pend.push_back(nif.note_row);
    end
    m_miss = (m_miss + nmiss > 255) ? 255 : m_miss + nmiss;
    m_tick = tick; m_hit = (nhit != 0); m_mp = (nmiss != 0);
  endtask

  task automatic step();
    check("ready_pre", nif.note_ready, m_run && (m_pend.size() == 0));
    model_update();
    @(posedge clk); #1;
    check("tick",  scroll_tick, m_tick);
    check("hit",   hit_pulse,   m_hit);
    check("missp", miss_pulse,  m_mp);
    check("score", score,       m_score);
    check("missc", miss_count,  m_miss);
    check("grid",  grid,        m_grid());
  endtask

  initial begin
    int n;
    n_rst = 1'b0; mode = 3'd0; diff_speed = 23'd4; level = 2'd1; btn = 4'd0;
    nif.note_valid = 1'b0; nif.note_row = 4'd0;
    m_clear_field(); m_run = 0; m_score = 0; m_miss = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grid", grid, 0);
    check("rst_score", score, 0);
    check("rst_miss", miss_count, 0);
    check("rst_pulses", {scroll_tick, hit_pulse, miss_pulse}, 3'b000);
    check("rst_ready", nif.note_ready, 1'b0);

    // Period: ticks on cycles 4, 8, 12 after RUN entry.
    n_rst = 1'b1; mode = PM;
    step();
    for (int c = 1; c <= 12; c++) begin
      step();
      check("period4", scroll_tick, (c % 4) == 0);
    end
    diff_speed = 23'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("period0", scroll_tick, 1'b1);
    end

    // Pipeline: single note falls through and is missed on the 8th tick.
    diff_speed = 23'd2;
    nif.note_valid = 1'b1; nif.note_row = 4'b0001;
    step();
    nif.note_valid = 1'b0;
    for (int i = 0; i < 20 && grid[3:0] != 4'b0001; i++) step();
    check("pipe_land", grid[3:0], 4'b0001);
    n = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin
      step();
      if (scroll_tick) begin
        n++;
        check("pipe_missp", miss_pulse, n == 8);
      end
    end
    check("pipe_ticks", n, 8);
    check("pipe_missc", miss_count, 8'd1);

    // Hits on strike row 0101 with level 3.
    diff_speed = 23'd3;
    nif.note_valid = 1'b1; nif.note_row = 4'b0101;
    step();
    nif.note_valid = 1'b0;
    for (int i = 0; i < 100 && grid[4*ROWS-1 -: 4] != 4'b0101; i++) step();
    check("hit_arrive", grid[4*ROWS-1 -: 4], 4'b0101);
    level = 2'd3; btn = 4'b0101;
    step();
    btn = 4'd0;
    check("hit_pulse", hit_pulse, 1'b1);
    check("hit_score", score, 16'd6);
    check("hit_clear", grid[4*ROWS-1 -: 4], 4'b0000);
    for (int i = 0; i < 10 && !scroll_tick; i++) step();
    check("hit_tick", scroll_tick, 1'b1);
    check("hit_nomiss", miss_pulse, 1'b0);
    check("hit_missc", miss_count, 8'd1);

    // Coincidence: handshake on the tick cycle lands directly in row 0.
    for (int i = 0; i < 10 && m_cnt < 2; i++) step();
    nif.note_valid = 1'b1; nif.note_row = 4'b1000;
    step();
    nif.note_valid = 1'b0;
    check("coin_tick", scroll_tick, 1'b1);
    check("coin_row0", grid[3:0], 4'b1000);
    check("coin_ready", nif.note_ready, 1'b1);

    // Press on an empty strike row.
    check("ghost_empty", grid[4*ROWS-1 -: 4], 4'b0000);
    btn = 4'b0010;
    step();
    btn = 4'd0;
`ifdef GUITAR_GHOST_PRESS_EN
    check("ghost_missc", miss_count, 8'd2);
`else
    check("ghost_missc", miss_count, 8'd1);
`endif

    // Abort mid-count, then reset.
    mode = 3'd3;
    step();
    check("abort_grid", grid, 0);
    check("abort_ready", nif.note_ready, 1'b0);
    check("abort_score", score, 16'd6);
    n_rst = 1'b0;
    step();
    check("rst2_all", {grid, score, miss_count, scroll_tick, hit_pulse, miss_pulse}, 0);
    n_rst = 1'b1; mode = PM;

    // Saturation of miss_count, then score.
    diff_speed = 23'd0; nif.note_valid = 1'b1; nif.note_row = 4'b1111; level = 2'd1;
    for (int i = 0; i < 120; i++) step();
    check("miss_sat", miss_count, 8'hFF);
    btn = 4'b1111; level = 2'd3;
    for (int i = 0; i < 5600; i++) step();
    check("score_sat", score, 16'hFFFF);
    btn = 4'd0; nif.note_valid = 1'b0;

    // Randomised run checked cycle by cycle against the model.
    n_rst = 1'b0; step(); n_rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      n_rst          = ($urandom_range(0, 199) != 0);
      mode           = ($urandom_range(0, 49) == 0) ? 3'd3 : PM;
      if ($urandom_range(0, 7) == 0) diff_speed = 23'($urandom_range(0, 5));
      level          = 2'($urandom_range(0, 3));
      btn            = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      nif.note_valid = 1'($urandom_range(0, 1));
      nif.note_row   = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
